// File: rtl/coef_ram_arbiter.sv
// Round-robin arbiter sharing the coefficient RAM read port between the L/R lowpass filters; grant is same-cycle,
// read data returns RAM_LAT cycles after grant; a losing requester simply holds req. Optional burst lock: COEF_ARB_LOCK_EN.
module coef_ram_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int RAM_LAT  = 1,
  parameter int MAX_LOCK = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_en,
  input  logic              reqL,
  input  logic [ADDR_W-1:0] addrL,
  output logic              gntL,
  output logic              rvalidL,
  output logic [DATA_W-1:0] coefL,
  input  logic              reqR,
  input  logic [ADDR_W-1:0] addrR,
  output logic              gntR,
  output logic              rvalidR,
  output logic [DATA_W-1:0] coefR,
  input  logic              lockL,
  input  logic              lockR,
  output logic [ADDR_W-1:0] RAM_coefs_addr,
  input  logic [DATA_W-1:0] RAM_coefs_dataout
);

  localparam logic SEL_L = 1'b0;
  localparam logic SEL_R = 1'b1;

  logic              ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RAM_LAT-1:0] pvld_q, pvld_d;
  logic [RAM_LAT-1:0] pown_q, pown_d;
  logic [DATA_W-1:0] coef_l_q, coef_l_d;
  logic [DATA_W-1:0] coef_r_q, coef_r_d;

  logic gnt_l, gnt_r;
  logic rr_l, rr_r;
  logic rvalid_l, rvalid_r;

`ifdef COEF_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  logic             owner_vld_q, owner_vld_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_l_act, lock_r_act, force_arb;
`else
  logic unused_lock;
  assign unused_lock = lockL | lockR;
`endif

  always_comb begin
    gnt_l = 1'b0;
    gnt_r = 1'b0;
    rr_l  = reqL && (!reqR || ptr_q == SEL_L);
    rr_r  = reqR && (!reqL || ptr_q == SEL_R);
`ifdef COEF_ARB_LOCK_EN
    lock_l_act = owner_vld_q && (owner_q == SEL_L) && lockL && reqL;
    lock_r_act = owner_vld_q && (owner_q == SEL_R) && lockR && reqR;
    force_arb  = (lock_cnt_q == LOCK_MAX);
    // A saturated lock hands one grant to the other side if it is waiting.
    if (force_arb && owner_vld_q && owner_q == SEL_L && reqR) begin
      gnt_r = 1'b1;
    end else if (force_arb && owner_vld_q && owner_q == SEL_R && reqL) begin
      gnt_l = 1'b1;
    end else if (!force_arb && lock_l_act) begin
      gnt_l = 1'b1;
    end else if (!force_arb && lock_r_act) begin
      gnt_r = 1'b1;
    end else begin
      gnt_l = rr_l;
      gnt_r = rr_r;
    end
`else
    gnt_l = rr_l;
    gnt_r = rr_r;
`endif
    if (reset) begin
      gnt_l = 1'b0;
      gnt_r = 1'b0;
    end
  end

`ifdef COEF_ARB_LOCK_EN
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    lock_cnt_d  = '0;
    if (gnt_l || gnt_r) begin
      owner_vld_d = 1'b1;
      owner_d     = gnt_r ? SEL_R : SEL_L;
    end
    if (!force_arb && ((gnt_l && lockL) || (gnt_r && lockR))) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_vld_q <= 1'b0;
      owner_q     <= SEL_L;
      lock_cnt_q  <= '0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end
`endif

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_l) ptr_d = SEL_R;
    if (gnt_r) ptr_d = SEL_L;
    // Sample strobe wins so every sample period starts arbitration on L.
    if (data_en) ptr_d = SEL_L;

    addr_d = addr_q;
    if (gnt_l) addr_d = addrL;
    if (gnt_r) addr_d = addrR;

    pvld_d    = '0;
    pown_d    = '0;
    pvld_d[0] = gnt_l | gnt_r;
    pown_d[0] = gnt_r;
    for (int i = 1; i < RAM_LAT; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pown_d[i] = pown_q[i-1];
    end

    rvalid_l = pvld_q[RAM_LAT-1] && (pown_q[RAM_LAT-1] == SEL_L);
    rvalid_r = pvld_q[RAM_LAT-1] && (pown_q[RAM_LAT-1] == SEL_R);
    coef_l_d = rvalid_l ? RAM_coefs_dataout : coef_l_q;
    coef_r_d = rvalid_r ? RAM_coefs_dataout : coef_r_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q    <= SEL_L;
      addr_q   <= '0;
      pvld_q   <= '0;
      pown_q   <= '0;
      coef_l_q <= '0;
      coef_r_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      pvld_q   <= pvld_d;
      pown_q   <= pown_d;
      coef_l_q <= coef_l_d;
      coef_r_q <= coef_r_d;
    end
  end

  assign gntL           = gnt_l;
  assign gntR           = gnt_r;
  assign rvalidL        = rvalid_l;
  assign rvalidR        = rvalid_r;
  assign coefL          = coef_l_d;
  assign coefR          = coef_r_d;
  assign RAM_coefs_addr = addr_d;

endmodule

// File: tb/tb_coef_ram_arbiter.sv
// Directed bench: dut1 uses RAM_LAT=1, dut2 uses RAM_LAT=2 for the latency and mid-flight reset cases.
module tb_coef_ram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic       reset, data_en, reqL, reqR, lockL, lockR;
  logic [6:0] addrL, addrR, ram_addr;
  logic       gntL, gntR, rvalidL, rvalidR;
  logic [7:0] coefL, coefR, ram_dout;

  logic       reset2, data_en2, reqL2, reqR2;
  logic [6:0] addrL2, addrR2, ram_addr2;
  logic       gntL2, gntR2, rvalidL2, rvalidR2;
  logic [7:0] coefL2, coefR2, ram_dout2;

  logic [0:5] lock_pat;

  function automatic logic [7:0] word(input logic [6:0] a);
    return {1'b0, a} + 8'h30;
  endfunction

  logic [6:0] ram1_a_q  = '0;
  logic [6:0] ram2_a1_q = '0;
  logic [6:0] ram2_a2_q = '0;
  always @(posedge clock) begin
    ram1_a_q  <= ram_addr;
    ram2_a1_q <= ram_addr2;
    ram2_a2_q <= ram2_a1_q;
  end
  assign ram_dout  = word(ram1_a_q);
  assign ram_dout2 = word(ram2_a2_q);

  coef_ram_arbiter #(.ADDR_W(7), .DATA_W(8), .RAM_LAT(1), .MAX_LOCK(4)) dut1 (
    .clock(clock), .reset(reset), .data_en(data_en),
    .reqL(reqL), .addrL(addrL), .gntL(gntL), .rvalidL(rvalidL), .coefL(coefL),
    .reqR(reqR), .addrR(addrR), .gntR(gntR), .rvalidR(rvalidR), .coefR(coefR),
    .lockL(lockL), .lockR(lockR),
    .RAM_coefs_addr(ram_addr), .RAM_coefs_dataout(ram_dout)
  );

  coef_ram_arbiter #(.ADDR_W(7), .DATA_W(8), .RAM_LAT(2), .MAX_LOCK(4)) dut2 (
    .clock(clock), .reset(reset2), .data_en(data_en2),
    .reqL(reqL2), .addrL(addrL2), .gntL(gntL2), .rvalidL(rvalidL2), .coefL(coefL2),
    .reqR(reqR2), .addrR(addrR2), .gntR(gntR2), .rvalidR(rvalidR2), .coefR(coefR2),
    .lockL(1'b0), .lockR(1'b0),
    .RAM_coefs_addr(ram_addr2), .RAM_coefs_dataout(ram_dout2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; data_en = 1'b0; reqL = 1'b0; reqR = 1'b0; lockL = 1'b0; lockR = 1'b0;
    addrL = '0; addrR = '0;
    reset2 = 1'b1; data_en2 = 1'b0; reqL2 = 1'b0; reqR2 = 1'b0; addrL2 = '0; addrR2 = '0;
    nxt; nxt;
    reset = 1'b0; reset2 = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_gntL", gntL, 0);       chk("rst_gntR", gntR, 0);
    chk("rst_rvalidL", rvalidL, 0); chk("rst_rvalidR", rvalidR, 0);
    chk("rst_coefL", coefL, 0);     chk("rst_coefR", coefR, 0);
    chk("rst_addr", ram_addr, 0);   chk("rst_addr2", ram_addr2, 0);
    nxt;

    // single left read
    reqL = 1'b1; addrL = 7'h05;
    @(negedge clock);
    chk("t1_gntL", gntL, 1); chk("t1_gntR", gntR, 0); chk("t1_addr", ram_addr, 7'h05);
    nxt;
    reqL = 1'b0; addrL = 7'h7f;
    @(negedge clock);
    chk("t1_rvalidL", rvalidL, 1); chk("t1_coefL", coefL, 8'h35);
    chk("t1_rvalidR", rvalidR, 0); chk("t1_addr_hold", ram_addr, 7'h05);
    chk("t1_gntL_off", gntL, 0);
    nxt;
    data_en = 1'b1;
    @(negedge clock);
    chk("t1_rvalidL_end", rvalidL, 0); chk("t1_coefL_hold", coefL, 8'h35);
    nxt;
    data_en = 1'b0;

    // both requesting: strict alternation starting at L
    reqL = 1'b1; reqR = 1'b1; addrL = 7'h10; addrR = 7'h20;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk($sformatf("t2_gntL_%0d", k), gntL, (k % 2) == 0);
      chk($sformatf("t2_gntR_%0d", k), gntR, (k % 2) == 1);
      chk($sformatf("t2_addr_%0d", k), ram_addr, ((k % 2) == 0) ? 7'h10 : 7'h20);
      if (k > 0) begin
        chk($sformatf("t2_rvalidL_%0d", k), rvalidL, (k % 2) == 1);
        chk($sformatf("t2_rvalidR_%0d", k), rvalidR, (k % 2) == 0);
        if ((k % 2) == 1) chk($sformatf("t2_coefL_%0d", k), coefL, 8'h40);
        else              chk($sformatf("t2_coefR_%0d", k), coefR, 8'h50);
      end
      nxt;
    end
    reqL = 1'b0; reqR = 1'b0;
    @(negedge clock);
    chk("t2_rvalidR_last", rvalidR, 1); chk("t2_coefR_last", coefR, 8'h50);
    chk("t2_rvalidL_last", rvalidL, 0);
    nxt;

    // data_en realigns the pointer, and overrides the post-grant update
    reqL = 1'b1; reqR = 1'b1;
    @(negedge clock); chk("t3_A_gntL", gntL, 1); nxt;
    reqL = 1'b0; reqR = 1'b0; data_en = 1'b1;
    @(negedge clock);
    chk("t3_B_nogrant", {gntL, gntR}, 2'b00); chk("t3_B_addr_hold", ram_addr, 7'h10);
    nxt;
    data_en = 1'b0; reqL = 1'b1; reqR = 1'b1;
    @(negedge clock); chk("t3_C_gntL", gntL, 1); chk("t3_C_gntR", gntR, 0); nxt;
    @(negedge clock); chk("t3_D_gntR", gntR, 1); nxt;
    data_en = 1'b1;
    @(negedge clock); chk("t3_E_gntL", gntL, 1); nxt;
    data_en = 1'b0;
    @(negedge clock); chk("t3_F_gntL", gntL, 1); chk("t3_F_gntR", gntR, 0); nxt;
    @(negedge clock); chk("t3_G_gntR", gntR, 1); nxt;
    reqL = 1'b0; reqR = 1'b0;
    @(negedge clock); nxt;

    // right only, back-to-back
    reqR = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addrR = 7'(k);
      @(negedge clock);
      chk($sformatf("t4_gntR_%0d", k), gntR, 1);
      chk($sformatf("t4_gntL_%0d", k), gntL, 0);
      chk($sformatf("t4_addr_%0d", k), ram_addr, k);
      if (k > 0) begin
        chk($sformatf("t4_rvalidR_%0d", k), rvalidR, 1);
        chk($sformatf("t4_coefR_%0d", k), coefR, 8'h30 + k - 1);
      end
      nxt;
    end
    reqR = 1'b0;
    @(negedge clock);
    chk("t4_rvalidR_last", rvalidR, 1); chk("t4_coefR_last", coefR, 8'h33);
    chk("t4_rvalidL", rvalidL, 0);
    nxt;
    @(negedge clock); chk("t4_rvalidR_end", rvalidR, 0); nxt;

    // RAM_LAT=2 latency, then reset with a read in flight
    reqL2 = 1'b1; addrL2 = 7'h09;
    @(negedge clock); chk("t5_gntL2", gntL2, 1); chk("t5_addr2", ram_addr2, 7'h09); nxt;
    reqL2 = 1'b0;
    @(negedge clock); chk("t5_rvalidL2_early", rvalidL2, 0); nxt;
    @(negedge clock); chk("t5_rvalidL2", rvalidL2, 1); chk("t5_coefL2", coefL2, 8'h39); nxt;
    reqL2 = 1'b1; addrL2 = 7'h0c;
    @(negedge clock); chk("t5_gntL2_b", gntL2, 1); nxt;
    reqL2 = 1'b0; reset2 = 1'b1;
    nxt;
    reset2 = 1'b0;
    @(negedge clock);
    chk("t5_post_rvalidL2", rvalidL2, 0); chk("t5_post_rvalidR2", rvalidR2, 0);
    chk("t5_post_coefL2", coefL2, 0);     chk("t5_post_coefR2", coefR2, 0);
    chk("t5_post_gnt2", {gntL2, gntR2}, 2'b00); chk("t5_post_addr2", ram_addr2, 0);
    nxt;
    @(negedge clock); chk("t5_post2_rvalidL2", rvalidL2, 0); nxt;

    // locked burst (alternation when the lock feature is compiled out)
`ifdef COEF_ARB_LOCK_EN
    lock_pat = 6'b111101;
`else
    lock_pat = 6'b101010;
`endif
    data_en = 1'b1; lockL = 1'b1;
    nxt;
    data_en = 1'b0; reqL = 1'b1; reqR = 1'b1; addrL = 7'h10; addrR = 7'h20;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk($sformatf("t6_gntL_%0d", k), gntL, lock_pat[k]);
      chk($sformatf("t6_gntR_%0d", k), gntR, !lock_pat[k]);
      nxt;
    end
    reqL = 1'b0; reqR = 1'b0; lockL = 1'b0;
    nxt;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
